// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access stage: funct3 encodings,
// sequencer states and the legality/alignment check applied at accept.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {IDLE, BUS, RESP} mem_state_t;

    // True when funct3 is legal for the direction and the address is naturally aligned.
    function automatic logic access_ok(input logic we, input logic [2:0] f3,
                                       input logic [1:0] addr_lo);
        logic legal;
        logic aligned;
        if (we) begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        end
        case (f3[1:0])
            2'd1:    aligned = ~addr_lo[0];
            2'd2:    aligned = (addr_lo == 2'b00);
            default: aligned = 1'b1;
        endcase
        return legal && aligned;
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Store lane steering: replicates byte/half store data across the word and
// builds the matching byte-enable mask from the low address bits.
module store_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o
);

    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = wdata_i;
        case (funct3_i)
            F3_B: begin
                wdata_o = {4{wdata_i[7:0]}};
                wstrb_o = 4'b0001 << addr_lo_i;
            end
            F3_H: begin
                wdata_o = {2{wdata_i[15:0]}};
                wstrb_o = 4'b0011 << addr_lo_i;
            end
            F3_W: begin
                wstrb_o = 4'b1111;
            end
            default: begin
                wstrb_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage sequencer: accepts one load/store, runs a single-beat bus
// transaction with timeout, and returns byte-shifted load data or a fault flag.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_wstrb_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_misaligned_o,
    output logic              resp_fault_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    mem_state_t        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mis_q, mis_d;
    logic              fault_q, fault_d;

    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              accept;
    logic [3:0]        lane_wstrb;
    logic [31:0]       lane_wdata;

    assign accept = req_valid_i && (state_q == IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            fault_q <= fault_d;
            if (accept) begin
                we_q    <= req_we_i;
                f3_q    <= req_funct3_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    cnt_d   = '0;
                    rdata_d = '0;
                    if (access_ok(req_we_i, req_funct3_i, req_addr_i[1:0])) begin
                        state_d = BUS;
                    end else begin
                        state_d = RESP;
                        mis_d   = 1'b1;
                    end
                end
            end
            BUS: begin
                if (mem_ready_i) begin
                    state_d = RESP;
                    rdata_d = we_q ? 32'd0 : (mem_rdata_i >> {addr_q[1:0], 3'b000});
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
                rdata_d = '0;
                mis_d   = 1'b0;
                fault_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    store_lane_align u_store_lane_align (
        .funct3_i  (f3_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .wstrb_o   (lane_wstrb),
        .wdata_o   (lane_wdata)
    );

    assign req_ready_o       = (state_q == IDLE);
    assign mem_valid_o       = (state_q == BUS);
    assign mem_we_o          = we_q;
    assign mem_addr_o        = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wstrb_o       = (mem_valid_o && we_q) ? lane_wstrb : 4'b0000;
    assign mem_wdata_o       = lane_wdata;
    assign resp_valid_o      = (state_q == RESP);
    assign resp_rdata_o      = rdata_q;
    assign resp_misaligned_o = mis_q;
    assign resp_fault_o      = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever resp_valid is seen.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int unsigned TO = 6;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_fault;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        fault;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_e;
    logic  resp_prev = 1'b0;
    int    checks = 0;
    int    failures = 0;

    mem_access_unit #(
        .ADDR_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_we_i          (req_we),
        .req_funct3_i      (req_funct3),
        .req_addr_i        (req_addr),
        .req_wdata_i       (req_wdata),
        .mem_valid_o       (mem_valid),
        .mem_ready_i       (mem_ready),
        .mem_we_o          (mem_we),
        .mem_addr_o        (mem_addr),
        .mem_wstrb_o       (mem_wstrb),
        .mem_wdata_o       (mem_wdata),
        .mem_rdata_i       (mem_rdata),
        .resp_valid_o      (resp_valid),
        .resp_rdata_o      (resp_rdata),
        .resp_misaligned_o (resp_misaligned),
        .resp_fault_o      (resp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            check1("resp_single_cycle", resp_prev, 1'b0);
            check1("resp_flags_exclusive", resp_misaligned && resp_fault, 1'b0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL resp_unexpected: got resp_valid=1 expected no response");
            end else begin
                mon_e = exp_q.pop_front();
                check32("resp_rdata", resp_rdata, mon_e.rdata);
                check1("resp_misaligned", resp_misaligned, mon_e.mis);
                check1("resp_fault", resp_fault, mon_e.fault);
            end
        end
        resp_prev = resp_valid;
    end

    // d = BUS cycle (1-based) on which mem_ready is raised; 0 means never.
    task automatic do_access(input string name, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int d,
                             input logic [31:0] exp_rdata, input logic exp_mis,
                             input logic exp_fault, input logic [3:0] exp_wstrb,
                             input logic [31:0] exp_wdata);
        resp_t e;
        logic  exp_bus;
        int    exp_lat;
        exp_bus = !exp_mis;
        exp_lat = exp_mis ? 1 : (((d == 0) ? int'(TO) : d) + 1);
        @(negedge clk);
        check1({name, " req_ready"}, req_ready, 1'b1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        e.rdata = exp_rdata;
        e.mis   = exp_mis;
        e.fault = exp_fault;
        exp_q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int cyc = 1; cyc <= exp_lat; cyc++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            check1({name, " resp_valid_timing"}, resp_valid, cyc == exp_lat);
            check1({name, " mem_valid"}, mem_valid, exp_bus && (cyc < exp_lat));
            if (exp_bus && cyc < exp_lat) begin
                check32({name, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
                check1({name, " mem_we"}, mem_we, we);
                check32({name, " mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, exp_wstrb});
                if (we) check32({name, " mem_wdata"}, mem_wdata, exp_wdata);
                if (cyc == d) begin
                    mem_ready = 1'b1;
                    mem_rdata = rdata;
                end
            end else begin
                check32({name, " mem_wstrb_idle"}, {28'd0, mem_wstrb}, 32'd0);
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        check1({name, " back_to_idle"}, req_ready, 1'b1);
        check1({name, " resp_cleared"}, resp_valid, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("reset req_ready", req_ready, 1'b1);
        check1("reset mem_valid", mem_valid, 1'b0);
        check1("reset resp_valid", resp_valid, 1'b0);
        check32("reset mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check32("reset resp_rdata", resp_rdata, 32'd0);
        check1("reset resp_misaligned", resp_misaligned, 1'b0);
        check1("reset resp_fault", resp_fault, 1'b0);
        rst = 1'b0;

        do_access("lw_aligned", 1'b0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 1,
                  32'hDEADBEEF, 1'b0, 1'b0, 4'b0000, 32'h0);
        do_access("lbu_byte3", 1'b0, F3_BU, 32'h103, 32'h0, 32'h80FF1234, 1,
                  32'h00000080, 1'b0, 1'b0, 4'b0000, 32'h0);
        do_access("lh_half1", 1'b0, F3_H, 32'h102, 32'h0, 32'hAABBCCDD, 2,
                  32'h0000AABB, 1'b0, 1'b0, 4'b0000, 32'h0);
        do_access("sh_upper", 1'b1, F3_H, 32'h102, 32'h0000ABCD, 32'h0, 3,
                  32'h0, 1'b0, 1'b0, 4'b1100, 32'hABCDABCD);
        do_access("sb_byte1", 1'b1, F3_B, 32'h201, 32'h0000005A, 32'h0, 1,
                  32'h0, 1'b0, 1'b0, 4'b0010, 32'h5A5A5A5A);
        do_access("lw_misaligned", 1'b0, F3_W, 32'h101, 32'h0, 32'h0, 1,
                  32'h0, 1'b1, 1'b0, 4'b0000, 32'h0);
        do_access("load_f3_3", 1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 1,
                  32'h0, 1'b1, 1'b0, 4'b0000, 32'h0);
        do_access("store_f3_4", 1'b1, F3_BU, 32'h100, 32'h0, 32'h0, 1,
                  32'h0, 1'b1, 1'b0, 4'b0000, 32'h0);
        do_access("sw_timeout", 1'b1, F3_W, 32'h104, 32'h12345678, 32'h0, 0,
                  32'h0, 1'b0, 1'b1, 4'b1111, 32'h12345678);

        // Reset lands on the second BUS cycle of a load; no response may follow.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F3_W;
        req_addr   = 32'h200;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check1("rst_mid bus_cycle1", mem_valid, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check1("rst_mid mem_valid", mem_valid, 1'b0);
        check1("rst_mid req_ready", req_ready, 1'b1);
        check1("rst_mid resp_valid", resp_valid, 1'b0);
        rst = 1'b0;

        do_access("lw_after_rst", 1'b0, F3_W, 32'h204, 32'h0, 32'h0BADF00D, 2,
                  32'h0BADF00D, 1'b0, 1'b0, 4'b0000, 32'h0);

        repeat (3) @(negedge clk);
        check32("scoreboard_drain", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
